dcm: RTL and testbench
======================

# dcm

Discard-and-commit stage directly downstream of the statistics stage in the MD/PHV pipeline. Buffers each metadata (MD) and packet-header-vector (PHV) pair in matched FIFOs, then handles each pair:
- addressed to this module with the discard flag set: dropped;
- addressed to this module without the flag: re-targeted to the next module ID and forwarded;
- addressed elsewhere: bypassed unchanged.

Drop/forward counters are readable over the localbus. The configuration-packet channel passes straight through.

## Interface
- LMID, 8'd8, local module ID matched against md[87:80]
- NMID, 8'd9, next module ID written into md[87:80] on forward
- FIFO_DEPTH, 16, entries per FIFO (power of 2)
- ALF_LEVEL, 12, used-count at or above which almost-full asserts

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_dcm_md / in_dcm_md_wr  in  256/1  MD word, single-cycle write strobe
- in_dcm_phv / in_dcm_phv_wr  in  1024/1  PHV word, strobe asserted in the same cycle as the MD strobe
- out_dcm_md_alf, out_dcm_phv_alf  out  1  backpressure to upstream
- out_dcm_md / out_dcm_md_wr  out  256/1  forwarded MD (registered)
- out_dcm_phv / out_dcm_phv_wr  out  1024/1  forwarded PHV (registered)
- in_dcm_md_alf, in_dcm_phv_alf  in  1  downstream backpressure
- cfg2dcm_cs_n  in  1  localbus select, low active
- dcm2cfg_ack_n  out  1  localbus acknowledge, low active
- cfg2dcm_rw  in  1  0 = write, 1 = read
- cfg2dcm_addr / cfg2dcm_wdata  in  32/32  localbus address and write data
- dcm2cfg_rdata  out  32  localbus read data
- cin_dcm_data / cin_dcm_data_wr  in  134/1  config packet in
- cout_dcm_ready  out  1  equals cin_dcm_ready (combinational)
- cout_dcm_data / cout_dcm_data_wr  out  134/1  config packet out, combinational passthrough of the inputs
- cin_dcm_ready  in  1  downstream config ready

## Operation
**Reset values.** All registered outputs are 0, except dcm2cfg_ack_n, which is 1. FIFOs are empty, counters are 0, and the state is IDLE.

**FIFOs.**
- Two show-ahead FIFOs (MD and PHV), written on their respective strobes.
- A strobe that arrives while its FIFO is full is discarded and sets sticky status bit 1 (overflow).
- out_*_alf = in_*_alf OR (that FIFO's used count ≥ ALF_LEVEL).

**FSM.**
- IDLE → SEND when both FIFOs are non-empty AND neither in_dcm_md_alf nor in_dcm_phv_alf is asserted. On this transition:
  - pop one entry from each FIFO;
  - latch the MD/PHV heads;
  - compute the action (drop, forward or bypass).
- SEND → IDLE unconditionally. In SEND:
  - forward: out md = {md[255:88], NMID, md[79:0]}, PHV unchanged, both write strobes high for 1 cycle;
  - bypass: MD and PHV unchanged, both strobes high for 1 cycle;
  - drop: both strobes stay low.
- In IDLE, out_*_wr = 0; data outputs hold their last values.

**Actions.**
- drop: md[87:80] == LMID and md[108] == 1
- forward: md[87:80] == LMID and md[108] == 0
- bypass: md[87:80] != LMID

**Counters** (update in the cycle the action is taken; all wrap modulo 2^width):
- fwd_cnt (32 bit): incremented on forward and bypass.
- drop_cnt (32 bit): incremented on drop.
- drop_bytes (64 bit): on drop, add zero-extended md[107:96].

**Register map** (word addresses):
- 0x00 control/status. Write bit 0 = 1 clears all counters and the overflow bit (self-clearing); a clear wins over a same-cycle increment. Read bit 1 = overflow, bit 2 = FSM in SEND.
- 0x04 fwd_cnt
- 0x08 drop_cnt
- 0x0C drop_bytes[31:0]
- 0x10 drop_bytes[63:32]
- Other addresses: reads return 0, writes are ignored.

## Timing
- Latency: with both FIFOs previously empty and alf low, a write strobe in cycle N produces out_*_wr in cycle N+2.
- Throughput: one pair per 2 cycles.
- Downstream alf is sampled only in IDLE. A pair already in SEND completes regardless of alf.
- Simultaneous FIFO write and pop in the same cycle: both take effect; the used count is unchanged.
- Localbus handshake:
  - cs_n is sampled low in cycle C → register access performed and ack_n = 0 from cycle C+1;
  - rdata is valid while ack_n = 0;
  - ack_n holds 0 until cs_n is sampled high, then returns to 1 in the next cycle;
  - exactly one access per cs_n assertion.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous); an in-flight pair is lost.

## Test plan
- Forward: MD with [87:80] = 8, [108] = 0 and PHV = 1024'hA5 written in cycle 0 → cycle 2: out_dcm_md[87:80] = 9, other MD bits unchanged, PHV = A5, both strobes high for 1 cycle; fwd_cnt reads 1.
- Drop: 3 MDs with [87:80] = 8, [108] = 1, [107:96] = 64 → no output strobes; drop_cnt = 3, drop_bytes lo = 192, hi = 0.
- Bypass: MD with [87:80] = 5 → output is bit-identical after 2 cycles; fwd_cnt increments.
- Backpressure: hold in_dcm_md_alf = 1 and write 12 pairs → out_*_alf = 1, no output strobes. Release alf → 12 pairs emerge in order at one pair per 2 cycles. A 17th write while full sets status bit 1.
- Localbus: read 0x08 → ack_n low from cs_n+1 with correct data until cs_n deasserts. Write 0x00 = 1 → all counters read 0.
- Reset: assert rst_n low while in SEND → outputs 0, ack_n = 1, FIFOs empty, counters 0.

Source files
------------

// File: rtl/dcm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dcm_fifo: show-ahead FIFO used for the MD and PHV buffers of dcm.
//   clk, rst_n     clock, asynchronous active-low reset
//   wr / wdata     write strobe and data (dropped when the FIFO is full)
//   rd             pop request (ignored when empty)
//   head           current head entry, valid whenever empty = 0
//   empty, alf     status; alf = used count >= ALF_LEVEL
//   ovf            one-cycle pulse when a write is dropped because full
// ---------------------------------------------------------------------------
module dcm_fifo #(
  parameter int W         = 256,
  parameter int DEPTH     = 16,
  parameter int ALF_LEVEL = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         alf,
  output logic         ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ALF_CNT  = (AW+1)'(ALF_LEVEL);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   used_reg;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign full  = (used_reg == FULL_CNT);
  assign empty = (used_reg == '0);
  assign alf   = (used_reg >= ALF_CNT);
  // Fullness is judged before any same-cycle pop, so a write into a full
  // FIFO is always dropped.
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;
  assign ovf   = wr & full;

  // Show-ahead: the head is read straight from the storage array.
  assign head = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers define content validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      used_reg   <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      used_reg <= used_reg + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule

// ---------------------------------------------------------------------------
// dcm: discard-and-commit stage. Buffers MD/PHV pairs, then drops, forwards
// (re-targeted to NMID) or bypasses each pair; counters on the localbus.
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_dcm_md/_wr, in_dcm_phv/_wr    upstream MD/PHV words and strobes
//   out_dcm_md_alf, out_dcm_phv_alf  backpressure to upstream
//   out_dcm_md/_wr, out_dcm_phv/_wr  registered outputs to downstream
//   in_dcm_md_alf, in_dcm_phv_alf    downstream backpressure
//   cfg2dcm_*, dcm2cfg_*             localbus (cs_n/ack_n low active)
//   cin_dcm_*, cout_dcm_*            config-packet passthrough
// Register map: 0x00 ctrl/status, 0x04 fwd_cnt, 0x08 drop_cnt,
//               0x0C drop_bytes[31:0], 0x10 drop_bytes[63:32]
// ---------------------------------------------------------------------------
module dcm #(
  parameter logic [7:0] LMID       = 8'd8,
  parameter logic [7:0] NMID       = 8'd9,
  parameter int         FIFO_DEPTH = 16,
  parameter int         ALF_LEVEL  = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [255:0]  in_dcm_md,
  input  logic          in_dcm_md_wr,
  input  logic [1023:0] in_dcm_phv,
  input  logic          in_dcm_phv_wr,
  output logic          out_dcm_md_alf,
  output logic          out_dcm_phv_alf,
  output logic [255:0]  out_dcm_md,
  output logic          out_dcm_md_wr,
  output logic [1023:0] out_dcm_phv,
  output logic          out_dcm_phv_wr,
  input  logic          in_dcm_md_alf,
  input  logic          in_dcm_phv_alf,
  input  logic          cfg2dcm_cs_n,
  output logic          dcm2cfg_ack_n,
  input  logic          cfg2dcm_rw,
  input  logic [31:0]   cfg2dcm_addr,
  input  logic [31:0]   cfg2dcm_wdata,
  output logic [31:0]   dcm2cfg_rdata,
  input  logic [133:0]  cin_dcm_data,
  input  logic          cin_dcm_data_wr,
  output logic          cout_dcm_ready,
  output logic [133:0]  cout_dcm_data,
  output logic          cout_dcm_data_wr,
  input  logic          cin_dcm_ready
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state_reg;
  logic [255:0]  md_head;
  logic [1023:0] phv_head;
  logic          md_empty, phv_empty;
  logic          md_alf, phv_alf;
  logic          md_ovf, phv_ovf;
  logic          start;
  logic          hit, is_drop;

  logic [31:0]   fwd_cnt_reg;
  logic [31:0]   drop_cnt_reg;
  logic [63:0]   drop_bytes_reg;
  logic          overflow_reg;

  logic          bus_access;
  logic          clear;
  logic [31:0]   rd_val;
  logic          unused_wdata;

  // Config channel is a pure passthrough.
  assign cout_dcm_data    = cin_dcm_data;
  assign cout_dcm_data_wr = cin_dcm_data_wr;
  assign cout_dcm_ready   = cin_dcm_ready;

  // Both FIFOs pop together so MD and PHV stay paired.
  dcm_fifo #(.W(256), .DEPTH(FIFO_DEPTH), .ALF_LEVEL(ALF_LEVEL)) u_md_fifo (
    .clk(clk), .rst_n(rst_n), .wr(in_dcm_md_wr), .wdata(in_dcm_md), .rd(start),
    .head(md_head), .empty(md_empty), .alf(md_alf), .ovf(md_ovf)
  );

  dcm_fifo #(.W(1024), .DEPTH(FIFO_DEPTH), .ALF_LEVEL(ALF_LEVEL)) u_phv_fifo (
    .clk(clk), .rst_n(rst_n), .wr(in_dcm_phv_wr), .wdata(in_dcm_phv), .rd(start),
    .head(phv_head), .empty(phv_empty), .alf(phv_alf), .ovf(phv_ovf)
  );

  assign out_dcm_md_alf  = in_dcm_md_alf | md_alf;
  assign out_dcm_phv_alf = in_dcm_phv_alf | phv_alf;

  // Downstream alf only gates the launch from IDLE; SEND always completes.
  assign start   = (state_reg == IDLE) & ~md_empty & ~phv_empty &
                   ~in_dcm_md_alf & ~in_dcm_phv_alf;
  assign hit     = (md_head[87:80] == LMID);
  assign is_drop = hit & md_head[108];

  // One access per cs_n assertion: ack_n = 1 means no access is pending yet.
  assign bus_access   = ~cfg2dcm_cs_n & dcm2cfg_ack_n;
  assign clear        = bus_access & ~cfg2dcm_rw & (cfg2dcm_addr == 32'h0) & cfg2dcm_wdata[0];
  assign unused_wdata = ^cfg2dcm_wdata[31:1];

  always_comb begin
    rd_val = 32'h0;
    case (cfg2dcm_addr)
      32'h00:  rd_val = {29'h0, (state_reg == SEND), overflow_reg, 1'b0};
      32'h04:  rd_val = fwd_cnt_reg;
      32'h08:  rd_val = drop_cnt_reg;
      32'h0C:  rd_val = drop_bytes_reg[31:0];
      32'h10:  rd_val = drop_bytes_reg[63:32];
      default: rd_val = 32'h0;
    endcase
  end

  // Pipeline: outputs are loaded on the IDLE->SEND edge so the strobe is
  // visible for exactly the SEND cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      out_dcm_md     <= '0;
      out_dcm_md_wr  <= 1'b0;
      out_dcm_phv    <= '0;
      out_dcm_phv_wr <= 1'b0;
    end else begin
      out_dcm_md_wr  <= 1'b0;
      out_dcm_phv_wr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SEND;
            if (!is_drop) begin
              out_dcm_md     <= hit ? {md_head[255:88], NMID, md_head[79:0]} : md_head;
              out_dcm_phv    <= phv_head;
              out_dcm_md_wr  <= 1'b1;
              out_dcm_phv_wr <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Counters and sticky overflow; a clear overrides a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_reg    <= '0;
      drop_cnt_reg   <= '0;
      drop_bytes_reg <= '0;
      overflow_reg   <= 1'b0;
    end else if (clear) begin
      fwd_cnt_reg    <= '0;
      drop_cnt_reg   <= '0;
      drop_bytes_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (md_ovf | phv_ovf) overflow_reg <= 1'b1;
      if (start) begin
        if (is_drop) begin
          drop_cnt_reg   <= drop_cnt_reg + 32'd1;
          drop_bytes_reg <= drop_bytes_reg + {52'h0, md_head[107:96]};
        end else begin
          fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
        end
      end
    end
  end

  // Localbus: read data is captured at access time and held with ack_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcm2cfg_ack_n <= 1'b1;
      dcm2cfg_rdata <= '0;
    end else if (cfg2dcm_cs_n) begin
      dcm2cfg_ack_n <= 1'b1;
    end else if (bus_access) begin
      dcm2cfg_ack_n <= 1'b0;
      if (cfg2dcm_rw) dcm2cfg_rdata <= rd_val;
    end
  end
endmodule

// File: tb/tb_dcm.sv
`timescale 1ns/1ps
// Directed self-checking bench for dcm.
module tb_dcm;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [255:0]  in_dcm_md = '0;
  logic          in_dcm_md_wr = 1'b0;
  logic [1023:0] in_dcm_phv = '0;
  logic          in_dcm_phv_wr = 1'b0;
  logic          out_dcm_md_alf, out_dcm_phv_alf;
  logic [255:0]  out_dcm_md;
  logic          out_dcm_md_wr;
  logic [1023:0] out_dcm_phv;
  logic          out_dcm_phv_wr;
  logic          in_dcm_md_alf = 1'b0;
  logic          in_dcm_phv_alf = 1'b0;
  logic          cfg2dcm_cs_n = 1'b1;
  logic          dcm2cfg_ack_n;
  logic          cfg2dcm_rw = 1'b1;
  logic [31:0]   cfg2dcm_addr = '0;
  logic [31:0]   cfg2dcm_wdata = '0;
  logic [31:0]   dcm2cfg_rdata;
  logic [133:0]  cin_dcm_data = '0;
  logic          cin_dcm_data_wr = 1'b0;
  logic          cout_dcm_ready;
  logic [133:0]  cout_dcm_data;
  logic          cout_dcm_data_wr;
  logic          cin_dcm_ready = 1'b0;

  dcm dut (
    .clk(clk), .rst_n(rst_n),
    .in_dcm_md(in_dcm_md), .in_dcm_md_wr(in_dcm_md_wr),
    .in_dcm_phv(in_dcm_phv), .in_dcm_phv_wr(in_dcm_phv_wr),
    .out_dcm_md_alf(out_dcm_md_alf), .out_dcm_phv_alf(out_dcm_phv_alf),
    .out_dcm_md(out_dcm_md), .out_dcm_md_wr(out_dcm_md_wr),
    .out_dcm_phv(out_dcm_phv), .out_dcm_phv_wr(out_dcm_phv_wr),
    .in_dcm_md_alf(in_dcm_md_alf), .in_dcm_phv_alf(in_dcm_phv_alf),
    .cfg2dcm_cs_n(cfg2dcm_cs_n), .dcm2cfg_ack_n(dcm2cfg_ack_n),
    .cfg2dcm_rw(cfg2dcm_rw), .cfg2dcm_addr(cfg2dcm_addr),
    .cfg2dcm_wdata(cfg2dcm_wdata), .dcm2cfg_rdata(dcm2cfg_rdata),
    .cin_dcm_data(cin_dcm_data), .cin_dcm_data_wr(cin_dcm_data_wr),
    .cout_dcm_ready(cout_dcm_ready), .cout_dcm_data(cout_dcm_data),
    .cout_dcm_data_wr(cout_dcm_data_wr), .cin_dcm_ready(cin_dcm_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [255:0]  got_md[$];
  logic [1023:0] got_phv[$];
  int            got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor: record every emitted pair with its cycle number.
  always @(negedge clk) begin
    if (out_dcm_md_wr || out_dcm_phv_wr) begin
      chk("wr_pair", 256'(out_dcm_phv_wr), 256'(out_dcm_md_wr));
      got_md.push_back(out_dcm_md);
      got_phv.push_back(out_dcm_phv);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [255:0] mk_md(input logic [7:0] id, input logic drp,
                                         input logic [11:0] len, input logic [31:0] tag);
    logic [255:0] m;
    m = 256'hFEDCBA98_76543210_0F1E2D3C_4B5A6978_11223344_55667788_99AABBCC_DDEEFF00;
    m[87:80]  = id;
    m[108]    = drp;
    m[107:96] = len;
    m[31:0]   = tag;
    return m;
  endfunction

  // Called at posedge+1; strobe is sampled at the next edge, returns at posedge+1.
  task automatic wr_pair(input logic [255:0] md, input logic [1023:0] phv);
    in_dcm_md = md; in_dcm_phv = phv;
    in_dcm_md_wr = 1'b1; in_dcm_phv_wr = 1'b1;
    @(posedge clk); #1;
    in_dcm_md_wr = 1'b0; in_dcm_phv_wr = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input string tag, input logic rw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
    int n;
    cfg2dcm_cs_n = 1'b0; cfg2dcm_rw = rw; cfg2dcm_addr = a; cfg2dcm_wdata = wd;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dcm2cfg_ack_n !== 1'b0 && n < 8);
    chk({tag, "_ack"}, 256'(dcm2cfg_ack_n), 256'd0);
    if (rw) chk(tag, 256'(dcm2cfg_rdata), 256'(exp_rd));
    cfg2dcm_cs_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dcm2cfg_ack_n !== 1'b1 && n < 8);
    chk({tag, "_rel"}, 256'(dcm2cfg_ack_n), 256'd1);
  endtask

  initial begin
    logic [255:0]  m, e;
    logic [1023:0] p;
    int n0;

    // ---- reset ----
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(1);
    chk("rst_md_wr", 256'(out_dcm_md_wr), 256'd0);
    chk("rst_phv_wr", 256'(out_dcm_phv_wr), 256'd0);
    chk("rst_md", out_dcm_md, 256'd0);
    chk("rst_ack_n", 256'(dcm2cfg_ack_n), 256'd1);
    chk("rst_rdata", 256'(dcm2cfg_rdata), 256'd0);
    chk("rst_alf", 256'({out_dcm_md_alf, out_dcm_phv_alf}), 256'd0);
    bus_xfer("rst_status", 1'b1, 32'h00, 32'h0, 32'h0);

    // ---- config passthrough ----
    cin_dcm_data = 134'h2A_DEADBEEF_12345678_9ABCDEF0_0F0F0F0F; cin_dcm_data_wr = 1'b1; cin_dcm_ready = 1'b1;
    #1;
    chk("cfg_data", 256'(cout_dcm_data), 256'(134'h2A_DEADBEEF_12345678_9ABCDEF0_0F0F0F0F));
    chk("cfg_ctl", 256'({cout_dcm_data_wr, cout_dcm_ready}), 256'd3);
    cin_dcm_data_wr = 1'b0; cin_dcm_ready = 1'b0;
    wait_cycles(1);

    // ---- forward: exact 2-cycle latency ----
    m = mk_md(8'd8, 1'b0, 12'd40, 32'h1111_0001);
    e = m; e[87:80] = 8'd9;
    wr_pair(m, 1024'hA5);
    chk("fwd_wr_early", 256'(out_dcm_md_wr), 256'd0);
    wait_cycles(1);
    chk("fwd_md_wr", 256'(out_dcm_md_wr), 256'd1);
    chk("fwd_phv_wr", 256'(out_dcm_phv_wr), 256'd1);
    chk("fwd_md", out_dcm_md, e);
    chk("fwd_phv", 256'(out_dcm_phv === 1024'hA5), 256'd1);
    wait_cycles(1);
    chk("fwd_wr_one_cycle", 256'({out_dcm_md_wr, out_dcm_phv_wr}), 256'd0);
    bus_xfer("fwd_cnt1", 1'b1, 32'h04, 32'h0, 32'd1);

    // ---- drop x3 ----
    n0 = got_md.size();
    for (int i = 0; i < 3; i++) wr_pair(mk_md(8'd8, 1'b1, 12'd64, 32'(i)), 1024'(i));
    wait_cycles(10);
    chk("drop_no_out", 256'(got_md.size() - n0), 256'd0);
    bus_xfer("drop_cnt", 1'b1, 32'h08, 32'h0, 32'd3);
    bus_xfer("drop_lo", 1'b1, 32'h0C, 32'h0, 32'd192);
    bus_xfer("drop_hi", 1'b1, 32'h10, 32'h0, 32'd0);

    // ---- bypass (drop bit set but not addressed here) ----
    m = mk_md(8'd5, 1'b1, 12'd7, 32'h2222_0002);
    p = {1020'h0, 4'h7} << 600;
    wr_pair(m, p);
    wait_cycles(1);
    chk("byp_md_wr", 256'(out_dcm_md_wr), 256'd1);
    chk("byp_md", out_dcm_md, m);
    chk("byp_phv", 256'(out_dcm_phv === p), 256'd1);
    wait_cycles(2);
    bus_xfer("byp_fwd_cnt", 1'b1, 32'h04, 32'h0, 32'd2);
    bus_xfer("bad_addr", 1'b1, 32'h14, 32'h0, 32'd0);

    // ---- backpressure: 12 pairs held, then drained in order ----
    n0 = got_md.size();
    in_dcm_md_alf = 1'b1;
    for (int i = 0; i < 11; i++) wr_pair(mk_md(8'd5, 1'b0, 12'd0, 32'(i)), 1024'(32'hB0B0_0000 + i));
    chk("bp_phv_alf_11", 256'(out_dcm_phv_alf), 256'd0);
    chk("bp_md_alf_pass", 256'(out_dcm_md_alf), 256'd1);
    wr_pair(mk_md(8'd5, 1'b0, 12'd0, 32'd11), 1024'(32'hB0B0_000B));
    chk("bp_phv_alf_12", 256'(out_dcm_phv_alf), 256'd1);
    wait_cycles(4);
    chk("bp_no_out", 256'(got_md.size() - n0), 256'd0);
    in_dcm_md_alf = 1'b0;
    wait_cycles(30);
    chk("bp_count", 256'(got_md.size() - n0), 256'd12);
    chk("bp_alf_released", 256'({out_dcm_md_alf, out_dcm_phv_alf}), 256'd0);
    if (got_md.size() >= n0 + 12) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("bp_md%0d", i), got_md[n0+i], mk_md(8'd5, 1'b0, 12'd0, 32'(i)));
        chk($sformatf("bp_phv%0d", i), 256'(got_phv[n0+i] === 1024'(32'hB0B0_0000 + i)), 256'd1);
        if (i > 0) chk($sformatf("bp_gap%0d", i), 256'(got_cyc[n0+i] - got_cyc[n0+i-1]), 256'd2);
      end
    end

    // ---- overflow: 17 writes into a 16-deep FIFO ----
    n0 = got_md.size();
    in_dcm_phv_alf = 1'b1;
    for (int i = 0; i < 17; i++) wr_pair(mk_md(8'd5, 1'b0, 12'd0, 32'(100 + i)), 1024'(100 + i));
    bus_xfer("ovf_status", 1'b1, 32'h00, 32'h0, 32'd2);
    bus_xfer("clear_wr", 1'b0, 32'h00, 32'd1, 32'd0);
    bus_xfer("clr_status", 1'b1, 32'h00, 32'h0, 32'd0);
    bus_xfer("clr_fwd", 1'b1, 32'h04, 32'h0, 32'd0);
    bus_xfer("clr_drop", 1'b1, 32'h08, 32'h0, 32'd0);
    bus_xfer("clr_bytes_lo", 1'b1, 32'h0C, 32'h0, 32'd0);
    bus_xfer("clr_bytes_hi", 1'b1, 32'h10, 32'h0, 32'd0);
    in_dcm_phv_alf = 1'b0;
    wait_cycles(40);
    chk("ovf_count", 256'(got_md.size() - n0), 256'd16);
    if (got_md.size() >= n0 + 16) begin
      chk("ovf_first", got_md[n0], mk_md(8'd5, 1'b0, 12'd0, 32'd100));
      chk("ovf_last", got_md[n0+15], mk_md(8'd5, 1'b0, 12'd0, 32'd115));
    end
    bus_xfer("ovf_fwd_cnt", 1'b1, 32'h04, 32'h0, 32'd16);

    // ---- localbus handshake timing on 0x08 ----
    wr_pair(mk_md(8'd8, 1'b1, 12'd5, 32'h0), 1024'h0);
    wait_cycles(4);
    cfg2dcm_cs_n = 1'b0; cfg2dcm_rw = 1'b1; cfg2dcm_addr = 32'h08;
    chk("lb_ack_before", 256'(dcm2cfg_ack_n), 256'd1);
    wait_cycles(1);
    chk("lb_ack_c1", 256'(dcm2cfg_ack_n), 256'd0);
    chk("lb_rdata_c1", 256'(dcm2cfg_rdata), 256'd1);
    wait_cycles(1);
    chk("lb_ack_hold", 256'(dcm2cfg_ack_n), 256'd0);
    chk("lb_rdata_hold", 256'(dcm2cfg_rdata), 256'd1);
    cfg2dcm_cs_n = 1'b1;
    wait_cycles(1);
    chk("lb_ack_release", 256'(dcm2cfg_ack_n), 256'd1);

    // ---- reset during SEND ----
    n0 = got_md.size();
    wr_pair(mk_md(8'd8, 1'b0, 12'd0, 32'h3333_0000), 1024'h1);
    wr_pair(mk_md(8'd5, 1'b0, 12'd0, 32'h3333_0001), 1024'h2);
    chk("mid_send_wr", 256'(out_dcm_md_wr), 256'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_wr", 256'({out_dcm_md_wr, out_dcm_phv_wr}), 256'd0);
    chk("mrst_md", out_dcm_md, 256'd0);
    chk("mrst_phv", 256'(out_dcm_phv === 1024'h0), 256'd1);
    chk("mrst_ack_n", 256'(dcm2cfg_ack_n), 256'd1);
    chk("mrst_rdata", 256'(dcm2cfg_rdata), 256'd0);
    wait_cycles(1);
    rst_n = 1'b1;
    n0 = got_md.size();
    wait_cycles(8);
    chk("mrst_fifo_empty", 256'(got_md.size() - n0), 256'd0);
    bus_xfer("mrst_status", 1'b1, 32'h00, 32'h0, 32'd0);
    bus_xfer("mrst_fwd", 1'b1, 32'h04, 32'h0, 32'd0);
    bus_xfer("mrst_drop", 1'b1, 32'h08, 32'h0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
